// File: rtl/carbon_arch_pkg.sv
// Architectural CSR map shared across the carbon core: addresses, MODEFLAGS bit
// positions and the byte-enable merge used by every CSR write path.
package carbon_arch_pkg;

  localparam logic [11:0] CARBON_CSR_MODEFLAGS = 12'h7C0;
  localparam logic [11:0] CARBON_CSR_EPC       = 12'h341;
  localparam logic [11:0] CARBON_CSR_CAUSE     = 12'h342;

  localparam int MODEFLAGS_STRICT = 0;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/carbon_csr_responder.sv
// CSR responder for CAUSE / EPC / MODEFLAGS with fixed response latency.
// Reads sample and writes commit at accept; the response is replayed later.
module carbon_csr_responder
  import carbon_arch_pkg::*;
#(
  parameter int          RESP_LATENCY  = 1,
  parameter logic [31:0] MODEFLAGS_RST = 32'(1) << MODEFLAGS_STRICT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [1:0]  req_priv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_epc,
  output logic [31:0] modeflags,
  output logic [31:0] cause
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // WAIT holds RESP_LATENCY-1 cycles; counter runs down to zero.
  localparam logic [1:0] WAIT_INIT = (RESP_LATENCY > 1) ? 2'(RESP_LATENCY - 2) : 2'd0;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] cause_q, epc_q, mf_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        accept;
  logic [31:0] dec_rdata;
  logic        dec_fault;
  logic        cause_we, mf_we;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;
  assign modeflags = mf_q;
  assign cause     = cause_q;

  // Access decode; an empty byte mask completes as a no-op on mapped CSRs.
  always_comb begin
    dec_rdata = '0;
    dec_fault = 1'b0;
    cause_we  = 1'b0;
    mf_we     = 1'b0;
    case (req_addr)
      CARBON_CSR_CAUSE:
        if (!req_write)           dec_rdata = cause_q;
        else if (req_wstrb != '0) begin
          if (req_priv == 2'd3)   cause_we  = 1'b1;
          else                    dec_fault = 1'b1;
        end
      CARBON_CSR_MODEFLAGS:
        if (!req_write)           dec_rdata = mf_q;
        else if (req_wstrb != '0) begin
          if (req_priv != 2'd0)   mf_we     = 1'b1;
          else                    dec_fault = 1'b1;
        end
      CARBON_CSR_EPC:
        if (!req_write)           dec_rdata = epc_q;
        else if (req_wstrb != '0) dec_fault = 1'b1;
      default:                    dec_fault = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:
        if (req_valid) begin
          if (RESP_LATENCY == 1) state_nxt = RESP;
          else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      WAIT:
        if (cnt == 2'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 2'd1;
      RESP:
        if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cause_q <= '0;
      epc_q   <= '0;
      mf_q    <= MODEFLAGS_RST;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rdata_q <= dec_rdata;
        fault_q <= dec_fault;
      end else if (rsp_valid && rsp_ready) begin
        rdata_q <= '0;
        fault_q <= 1'b0;
      end
      if (accept && mf_we) mf_q <= apply_wstrb(mf_q, req_wdata, req_wstrb);
      // A trap overrides a CAUSE write landing on the same edge.
      if (trap_valid) begin
        cause_q <= trap_cause;
        epc_q   <= trap_epc;
      end else if (accept && cause_we) begin
        cause_q <= apply_wstrb(cause_q, req_wdata, req_wstrb);
      end
    end
  end

endmodule

// File: tb/tb_carbon_csr_responder.sv
// Directed bench: latency-1 instance for CSR behaviour, latency-3 instance for
// backpressure and mid-transaction reset.
module tb_carbon_csr_responder;
  import carbon_arch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid3;
  logic [11:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [1:0]  req_priv;
  logic        rsp_ready, rsp_ready3;
  logic        trap_valid;
  logic [31:0] trap_cause, trap_epc;

  logic        req_ready, rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata, modeflags, cause;
  logic        req_ready3, rsp_valid3, rsp_fault3;
  logic [31:0] rsp_rdata3, modeflags3, cause3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  carbon_csr_responder #(.RESP_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_priv(req_priv), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .modeflags(modeflags),
    .cause(cause));

  carbon_csr_responder #(.RESP_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_priv(req_priv), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_rdata(rsp_rdata3), .rsp_fault(rsp_fault3), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .modeflags(modeflags3),
    .cause(cause3));

  // One transaction on the latency-1 instance; lat counts sample points after accept.
  task automatic do_txn(input logic [11:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] p, input logic trap,
                        output logic [31:0] rd, output logic f, output int lat);
    req_addr = a; req_write = w; req_wdata = d; req_wstrb = s; req_priv = p;
    req_valid = 1'b1; trap_valid = trap;
    @(posedge clk); #1;
    req_valid = 1'b0; trap_valid = 1'b0; req_write = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) lat = 99;
    rd = rsp_rdata; f = rsp_fault;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", rsp_fault); end
    n_cmp++; if (modeflags !== 32'h1) begin n_err++; $display("FAIL rst_modeflags: got %h want 1", modeflags); end
    n_cmp++; if (cause !== 32'h0) begin n_err++; $display("FAIL rst_cause: got %h want 0", cause); end
    n_cmp++; if (req_ready3 !== 1'b1 || modeflags3 !== 32'h1) begin n_err++; $display("FAIL rst_dut3: got ready %b mf %h want 1 / 1", req_ready3, modeflags3); end
  endtask

  task automatic test_latency3;
    int bad = 0;
    req_addr = CARBON_CSR_MODEFLAGS; req_write = 1'b0; req_priv = 2'd0; req_wstrb = 4'h0;
    req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      if (rsp_valid3 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL lat3_early: got %0d early valid samples want 0", bad); end
    n_cmp++; if (rsp_valid3 !== 1'b1 || rsp_rdata3 !== 32'h1 || rsp_fault3 !== 1'b0)
      begin n_err++; $display("FAIL lat3_resp: got v%b d%h f%b want v1 d00000001 f0", rsp_valid3, rsp_rdata3, rsp_fault3); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid3 !== 1'b1 || rsp_rdata3 !== 32'h1 || rsp_fault3 !== 1'b0 || req_ready3 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL lat3_hold: got %0d unstable cycles want 0", bad); end
    rsp_ready3 = 1'b1;
    @(posedge clk); #1;
    rsp_ready3 = 1'b0;
    n_cmp++; if (req_ready3 !== 1'b1 || rsp_valid3 !== 1'b0)
      begin n_err++; $display("FAIL lat3_release: got ready %b valid %b want 1 0", req_ready3, rsp_valid3); end
  endtask

  task automatic test_modeflags;
    logic [31:0] rd; logic f; int lat;
    do_txn(CARBON_CSR_MODEFLAGS, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, rd, f, lat);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL mf_read_rdata: got %h want 00000001", rd); end
    n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL mf_read_fault: got %b want 0", f); end
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL mf_read_latency: got %0d want 1", lat); end
    do_txn(CARBON_CSR_MODEFLAGS, 1'b1, 32'h0, 4'hF, 2'd1, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL mf_wr_p1: got f%b d%h want f0 d0", f, rd); end
    n_cmp++; if (modeflags !== 32'h0) begin n_err++; $display("FAIL mf_wr_p1_val: got %h want 0", modeflags); end
    do_txn(CARBON_CSR_MODEFLAGS, 1'b1, 32'h0, 4'hF, 2'd0, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b1) begin n_err++; $display("FAIL mf_wr_p0_fault: got %b want 1", f); end
    do_txn(CARBON_CSR_MODEFLAGS, 1'b1, 32'h0000_00A5, 4'hF, 2'd0, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b1 || modeflags !== 32'h0) begin n_err++; $display("FAIL mf_wr_p0_noupd: got f%b mf %h want f1 mf 0", f, modeflags); end
    do_txn(CARBON_CSR_MODEFLAGS, 1'b1, 32'h1234_5678, 4'b0101, 2'd2, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b0 || modeflags !== 32'h0034_0078) begin n_err++; $display("FAIL mf_wr_bytes: got f%b mf %h want f0 mf 00340078", f, modeflags); end
    do_txn(CARBON_CSR_MODEFLAGS, 1'b1, 32'hFFFF_FFFF, 4'h0, 2'd1, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b0 || modeflags !== 32'h0034_0078) begin n_err++; $display("FAIL mf_wr_nostrb: got f%b mf %h want f0 mf 00340078", f, modeflags); end
  endtask

  task automatic test_cause_epc;
    logic [31:0] rd; logic f; int lat;
    do_txn(CARBON_CSR_CAUSE, 1'b1, 32'hDEAD_BEEF, 4'hF, 2'd2, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b1 || cause !== 32'h0) begin n_err++; $display("FAIL cause_wr_p2: got f%b cause %h want f1 cause 0", f, cause); end
    do_txn(CARBON_CSR_CAUSE, 1'b1, 32'hDEAD_BEEF, 4'hF, 2'd3, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b0 || cause !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cause_wr_p3: got f%b cause %h want f0 cause deadbeef", f, cause); end
    do_txn(CARBON_CSR_CAUSE, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b0 || rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cause_rd_p0: got f%b d%h want f0 deadbeef", f, rd); end
    do_txn(CARBON_CSR_EPC, 1'b1, 32'h1111_1111, 4'hF, 2'd3, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL epc_wr_fault: got f%b d%h want f1 d0", f, rd); end
  endtask

  task automatic test_trap;
    logic [31:0] rd; logic f; int lat;
    trap_cause = 32'h0000_0020; trap_epc = 32'h0000_0000; trap_valid = 1'b1;
    @(posedge clk); #1;
    trap_valid = 1'b0;
    n_cmp++; if (cause3 !== 32'h0000_0020) begin n_err++; $display("FAIL trap_cause3: got %h want 00000020", cause3); end
    do_txn(CARBON_CSR_CAUSE, 1'b0, 32'h0, 4'h0, 2'd1, 1'b0, rd, f, lat);
    n_cmp++; if (rd !== 32'h0000_0020 || f !== 1'b0) begin n_err++; $display("FAIL trap_cause_rd: got d%h f%b want 00000020 f0", rd, f); end
    do_txn(CARBON_CSR_EPC, 1'b0, 32'h0, 4'h0, 2'd1, 1'b0, rd, f, lat);
    n_cmp++; if (rd !== 32'h0 || f !== 1'b0) begin n_err++; $display("FAIL trap_epc_rd: got d%h f%b want 0 f0", rd, f); end
    trap_cause = 32'h0000_0007; trap_epc = 32'h8000_1234; trap_valid = 1'b1;
    @(posedge clk); #1;
    trap_valid = 1'b0;
    do_txn(CARBON_CSR_EPC, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, rd, f, lat);
    n_cmp++; if (rd !== 32'h8000_1234) begin n_err++; $display("FAIL trap_epc2_rd: got %h want 80001234", rd); end
  endtask

  task automatic test_trap_collision;
    logic [31:0] rd; logic f; int lat;
    trap_cause = 32'h0000_000B; trap_epc = 32'h0000_0044;
    do_txn(CARBON_CSR_CAUSE, 1'b1, 32'h0, 4'hF, 2'd3, 1'b1, rd, f, lat);
    n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL collide_fault: got %b want 0", f); end
    n_cmp++; if (cause !== 32'h0000_000B) begin n_err++; $display("FAIL collide_cause: got %h want 0000000b", cause); end
  endtask

  task automatic test_unmapped;
    logic [31:0] rd; logic f; int lat;
    do_txn(12'hFFF, 1'b0, 32'h0, 4'h0, 2'd3, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got f%b d%h want f1 d0", f, rd); end
    do_txn(12'hFFF, 1'b1, 32'hFFFF_FFFF, 4'hF, 2'd3, 1'b0, rd, f, lat);
    n_cmp++; if (f !== 1'b1 || modeflags !== 32'h0034_0078 || cause !== 32'h0000_000B)
      begin n_err++; $display("FAIL unmapped_wr: got f%b mf %h cause %h want f1 00340078 0000000b", f, modeflags, cause); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    req_addr = CARBON_CSR_MODEFLAGS; req_write = 1'b0; req_priv = 2'd0;
    req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0; rsp_ready3 = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if (req_ready3 !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", req_ready3); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid3 !== 1'b0) seen++;
    end
    rsp_ready3 = 1'b0;
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst_noresp: got %0d valid cycles want 0", seen); end
    n_cmp++; if (modeflags !== 32'h1) begin n_err++; $display("FAIL midrst_mf: got %h want 1", modeflags); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_wstrb = '0; req_priv = '0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    trap_valid = 1'b0; trap_cause = '0; trap_epc = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset;
    test_latency3;
    test_modeflags;
    test_cause_epc;
    test_trap;
    test_trap_collision;
    test_unmapped;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
